// File: rtl/bcd_pkg.sv
// Shared BCD digit type and digit limits for the up/down display counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with increment/decrement, rollover gating and parallel load.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       upd,
  input  logic       wrap_en,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       is_max,
  output logic       is_min
);

  bcd_digit_t q_next;

  assign is_max = (q == BCD_MAX);
  assign is_min = (q == BCD_MIN);

  // Load wins over stepping; a digit at its boundary only rolls over when wrap_en allows it
  always_comb begin
    q_next = q;
    if (ld) begin
      q_next = ld_val;
    end else if (step) begin
      if (upd) begin
        if (!is_max)      q_next = q + 4'd1;
        else if (wrap_en) q_next = BCD_MIN;
      end else begin
        if (!is_min)      q_next = q - 4'd1;
        else if (wrap_en) q_next = BCD_MAX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= BCD_MIN;
    else      q <= q_next;
  end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit packed-BCD up/down counter with per-digit load, sync clear, tick prescaler
// and wrap/saturate behaviour at the all-9 / all-0 limits.
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS = 8,
  parameter  int unsigned TICK_DIV   = 1,
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    upd,
  input  logic                    sat_mode,
  input  logic                    clear,
  input  logic                    load,
  input  logic [IDX_W-1:0]        load_idx,
  input  logic [3:0]              load_digit,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap,
  output logic                    at_limit,
  output logic                    load_err
);

  logic [NUM_DIGITS-1:0] is_max;
  logic [NUM_DIGITS-1:0] is_min;
  logic [NUM_DIGITS-1:0] carry;
  logic [NUM_DIGITS-1:0] step;
  logic [NUM_DIGITS-1:0] ld;
  logic                  limit;
  logic                  idx_ok;
  logic                  load_ok;
  logic                  tick;
  logic                  wrap_en;
  bcd_digit_t            ld_val;

  // carry[i]: every digit below i sits at the boundary for the current direction
  always_comb begin
    logic run;
    run   = 1'b1;
    carry = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      carry[i] = run;
      run      = run & (upd ? is_max[i] : is_min[i]);
    end
    limit = run;
  end

  assign at_limit = limit;
  assign wrap_en  = ~(sat_mode & limit);

  // A full-range index field cannot address a missing digit
  if ((1 << IDX_W) == NUM_DIGITS) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    assign idx_ok = (load_idx < IDX_W'(NUM_DIGITS));
  end

  assign load_ok = idx_ok & (load_digit <= BCD_MAX);

  if (TICK_DIV == 1) begin : g_no_psc
    assign tick = en & ~clear & ~load;
  end else begin : g_psc
    localparam int unsigned PSC_W = $clog2(TICK_DIV);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);

    logic [PSC_W-1:0] psc;

    assign tick = en & ~clear & ~load & (psc == PSC_LAST);

    // Load freezes the prescaler; dropping enable restarts the division
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        psc <= '0;
      end else if (clear) begin
        psc <= '0;
      end else if (!load) begin
        if (!en)                 psc <= '0;
        else if (psc == PSC_LAST) psc <= '0;
        else                      psc <= psc + PSC_W'(1);
      end
    end
  end

  // Clear is applied as a zero load into every digit
  assign ld_val = clear ? BCD_MIN : load_digit;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign step[i] = tick & carry[i];
    assign ld[i]   = clear | (load & load_ok & (load_idx == IDX_W'(i)));

    bcd_digit_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .step    (step[i]),
      .upd     (upd),
      .wrap_en (wrap_en),
      .ld      (ld[i]),
      .ld_val  (ld_val),
      .q       (count[4*i +: 4]),
      .is_max  (is_max[i]),
      .is_min  (is_min[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= tick & limit & ~sat_mode;
      load_err <= ~clear & load & ~load_ok;
    end
  end

endmodule
